sensor_request_ctrl: RTL and testbench

Upstream stage of sensor_mode in the traffic controller. Synchronizes and debounces the raw vehicle-loop sensor and the timed/sensor mode switch. Drives sensor_mode's enable_sensor_mode level and its one-clock SET_srl pulse. Throttles requests with cycle_done feedback, which is sensor_mode's counter3_RST, plus a holdoff window.

---
 rtl/sensor_request_ctrl_pkg.sv | 15 +
 rtl/sensor_request_ctrl_sync_2ff.sv | 25 ++
 rtl/sensor_request_ctrl.sv | 137 +++++++++++++
 tb/tb_sensor_request_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_request_ctrl_pkg.sv
// Shared state encodings and default timing constants for the sensor request path.
// Used by sensor_request_ctrl and by sensor_mode so both agree on the FSM encoding.
package sensor_request_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_FIRE     = 3'd2;
    localparam logic [2:0] ST_BUSY     = 3'd3;
    localparam logic [2:0] ST_HOLDOFF  = 3'd4;

    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int HOLDOFF_CYCLES_DEF  = 16;
    localparam int CNT_W_DEF           = 5;

endpackage

// File: rtl/sensor_request_ctrl_sync_2ff.sv
// 1-bit two-flop synchronizer with async active-high reset.
// Latency: output follows input after 2 rising edges; no backpressure.
module sensor_request_ctrl_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sensor_request_ctrl.sv
// Debounces the vehicle-loop sensor and issues one SET_srl pulse per sensor_mode cycle.
// Latency: SET_srl after DEBOUNCE_CYCLES+3 edges; throttled by cycle_done plus holdoff. Option: SENSOR_LATCH_EN.
module sensor_request_ctrl
    import sensor_request_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SENSOR_raw,
    input  logic       MODE_sel,
    input  logic       cycle_done,
    output logic       enable_sensor_mode,
    output logic       SET_srl,
    output logic       req_busy,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             w_sensor_s;
    logic             w_mode_s;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_enable;
    logic             w_holdoff_done;

    sensor_request_ctrl_sync_2ff u_sync_sensor (
        .i_clk (CLOCK),
        .i_rst (RESET),
        .i_d   (SENSOR_raw),
        .o_q   (w_sensor_s)
    );

    sensor_request_ctrl_sync_2ff u_sync_mode (
        .i_clk (CLOCK),
        .i_rst (RESET),
        .i_d   (MODE_sel),
        .o_q   (w_mode_s)
    );

    assign w_holdoff_done = (r_state == ST_HOLDOFF) && (r_cnt == HOLD_LAST);

`ifdef SENSOR_LATCH_EN
    logic r_pending;

    // A car seen while the light sequence runs is remembered and served straight after holdoff.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_pending <= 1'b0;
        end else if (w_holdoff_done) begin
            r_pending <= 1'b0;
        end else if (((r_state == ST_BUSY) || (r_state == ST_HOLDOFF)) && w_sensor_s) begin
            r_pending <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && w_sensor_s) begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_sensor_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt < DEB_MAX) begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end else begin
                    w_state_nxt = ST_FIRE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FIRE: begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = '0;
            end
            ST_BUSY: begin
                if (cycle_done) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLDOFF: begin
                if (w_holdoff_done) begin
                    w_cnt_nxt   = '0;
`ifdef SENSOR_LATCH_EN
                    w_state_nxt = r_pending ? ST_FIRE : ST_IDLE;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_enable <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Mode only changes between requests so sensor_mode never sees it mid-sequence.
            if (r_state == ST_IDLE) begin
                r_enable <= w_mode_s;
            end
        end
    end

    assign enable_sensor_mode = r_enable;
    assign SET_srl            = (r_state == ST_FIRE);
    assign req_busy           = (r_state == ST_FIRE) || (r_state == ST_BUSY) || (r_state == ST_HOLDOFF);
    assign state_o            = r_state;

endmodule

// File: tb/tb_sensor_request_ctrl.sv
// Bench for sensor_request_ctrl: expected SET_srl edge numbers are queued at stimulus time.
// Every sampled cycle matches observed pulses against the queue.
module tb_sensor_request_ctrl;

    logic       CLOCK      = 1'b0;
    logic       RESET      = 1'b1;
    logic       SENSOR_raw = 1'b0;
    logic       MODE_sel   = 1'b0;
    logic       cycle_done = 1'b0;
    logic       enable_sensor_mode;
    logic       SET_srl;
    logic       req_busy;
    logic [2:0] state_o;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int exp_q[$];
    bit prev_set = 1'b0;
    bit got_pulse = 1'b0;

    sensor_request_ctrl dut (
        .CLOCK              (CLOCK),
        .RESET              (RESET),
        .SENSOR_raw         (SENSOR_raw),
        .MODE_sel           (MODE_sel),
        .cycle_done         (cycle_done),
        .enable_sensor_mode (enable_sensor_mode),
        .SET_srl            (SET_srl),
        .req_busy           (req_busy),
        .state_o            (state_o)
    );

    always #10 CLOCK = ~CLOCK;

    always @(posedge CLOCK) edge_cnt <= edge_cnt + 1;

    task automatic tick();
        int e;
        @(negedge CLOCK);
        if (prev_set) begin
            checks++;
            if (SET_srl !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width: SET_srl=%b at edge %0d, required 0", SET_srl, edge_cnt);
            end
        end
        if (SET_srl === 1'b1) begin
            got_pulse = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: SET_srl high at edge %0d, none expected", edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (edge_cnt != e) begin
                    errors++;
                    $display("FAIL pulse_edge: SET_srl high at edge %0d, required edge %0d", edge_cnt, e);
                end
            end
        end
        prev_set = (SET_srl === 1'b1);
    endtask

    task automatic wait_pulse(input int limit, input string name);
        got_pulse = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (got_pulse) break;
        end
        if (!got_pulse) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no SET_srl within %0d cycles, required one", name, limit);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        SENSOR_raw = 1'b0;
        MODE_sel   = 1'b0;
        cycle_done = 1'b0;
        tick();
        tick();
        RESET    = 1'b0;
        prev_set = 1'b0;
    endtask

    task automatic arm_sensor_mode();
        MODE_sel = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        SENSOR_raw = 1'b1;
        MODE_sel   = 1'b0;
        #5;
        checks++;
        if ({enable_sensor_mode, SET_srl, req_busy, state_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: en/set/busy/state=%b/%b/%b/%0d, required all 0",
                     enable_sensor_mode, SET_srl, req_busy, state_o);
        end
        #20;
        RESET = 1'b0;
        repeat (19) tick();
        checks++;
        if (enable_sensor_mode !== 1'b0) begin
            errors++;
            $display("FAIL idle_enable: enable_sensor_mode=%b, required 0", enable_sensor_mode);
        end
        checks++;
        if (state_o !== 3'd0 || req_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: state_o=%0d req_busy=%b, required 0/0", state_o, req_busy);
        end
        SENSOR_raw = 1'b0;
    endtask

    task automatic test_nominal();
        do_reset();
        arm_sensor_mode();
        checks++;
        if (enable_sensor_mode !== 1'b1) begin
            errors++;
            $display("FAIL nominal_enable: enable_sensor_mode=%b, required 1", enable_sensor_mode);
        end
        SENSOR_raw = 1'b1;
        exp_q.push_back(edge_cnt + 11);
        repeat (10) tick();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL nominal_debounce: state_o=%0d, required 1", state_o);
        end
        tick();
        checks++;
        if (state_o !== 3'd2 || req_busy !== 1'b1 || SET_srl !== 1'b1) begin
            errors++;
            $display("FAIL nominal_fire: state_o=%0d req_busy=%b SET_srl=%b, required 2/1/1",
                     state_o, req_busy, SET_srl);
        end
        tick();
        checks++;
        if (state_o !== 3'd3 || req_busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy: state_o=%0d req_busy=%b, required 3/1", state_o, req_busy);
        end
    endtask

    task automatic test_holdoff();
        int h;
        repeat (3) tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL holdoff_wait_busy: state_o=%0d, required 3", state_o);
        end
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        h = edge_cnt;
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL holdoff_enter: state_o=%0d, required 4", state_o);
        end
`ifdef SENSOR_LATCH_EN
        exp_q.push_back(h + 16);
`else
        exp_q.push_back(h + 25);
`endif
        repeat (15) tick();
        checks++;
        if (state_o !== 3'd4 || req_busy !== 1'b1) begin
            errors++;
            $display("FAIL holdoff_last: state_o=%0d req_busy=%b, required 4/1", state_o, req_busy);
        end
        tick();
`ifdef SENSOR_LATCH_EN
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL holdoff_latch_fire: state_o=%0d, required 2", state_o);
        end
`else
        checks++;
        if (state_o !== 3'd0 || req_busy !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_exit: state_o=%0d req_busy=%b, required 0/0", state_o, req_busy);
        end
        wait_pulse(12, "holdoff_redebounce");
`endif
        SENSOR_raw = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        arm_sensor_mode();
        SENSOR_raw = 1'b1;
        repeat (5) tick();
        SENSOR_raw = 1'b0;
        tick();
        SENSOR_raw = 1'b1;
        exp_q.push_back(edge_cnt + 11);
        wait_pulse(15, "glitch");
        SENSOR_raw = 1'b0;
    endtask

    task automatic test_mode_change();
        do_reset();
        arm_sensor_mode();
        SENSOR_raw = 1'b1;
        exp_q.push_back(edge_cnt + 11);
        repeat (9) tick();
        SENSOR_raw = 1'b0;
        wait_pulse(5, "mode_pulse");
        MODE_sel = 1'b0;
        repeat (4) tick();
        checks++;
        if (state_o !== 3'd3 || enable_sensor_mode !== 1'b1) begin
            errors++;
            $display("FAIL mode_busy_hold: state_o=%0d enable=%b, required 3/1", state_o, enable_sensor_mode);
        end
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        repeat (15) tick();
        checks++;
        if (state_o !== 3'd4 || enable_sensor_mode !== 1'b1) begin
            errors++;
            $display("FAIL mode_holdoff_hold: state_o=%0d enable=%b, required 4/1", state_o, enable_sensor_mode);
        end
        tick();
        checks++;
        if (state_o !== 3'd0 || enable_sensor_mode !== 1'b1) begin
            errors++;
            $display("FAIL mode_idle_entry: state_o=%0d enable=%b, required 0/1", state_o, enable_sensor_mode);
        end
        tick();
        checks++;
        if (enable_sensor_mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_drop: enable=%b, required 0", enable_sensor_mode);
        end
        SENSOR_raw = 1'b1;
        repeat (20) tick();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL mode_timed_idle: state_o=%0d, required 0", state_o);
        end
        SENSOR_raw = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        arm_sensor_mode();
        SENSOR_raw = 1'b1;
        repeat (7) tick();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL areset_debounce: state_o=%0d, required 1", state_o);
        end
        #5;
        RESET = 1'b1;
        #1;
        checks++;
        if ({enable_sensor_mode, SET_srl, req_busy, state_o} !== 6'b0) begin
            errors++;
            $display("FAIL areset_immediate: en/set/busy/state=%b/%b/%b/%0d, required all 0",
                     enable_sensor_mode, SET_srl, req_busy, state_o);
        end
        #2;
        RESET = 1'b0;
        exp_q.push_back(edge_cnt + 12);
        wait_pulse(16, "areset_redebounce");
        SENSOR_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_holdoff();
        test_glitch();
        test_mode_change();
        test_async_reset();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d pulses never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
